// File: rtl/blram_ctrl.sv
// ----------------------------------------------------------------------------
// blram_ctrl
//
// Purpose:
//   Master for a single-port block RAM with a registered read port. CPU-side
//   commands become correctly timed RAM cycles, and the RAM's one-cycle read
//   latency is hidden behind a valid/ready read stream.
//
//   Commands:
//     op 00  read burst with backpressure
//     op 01  single write (len ignored)
//     op 10  fill burst with constant data
//     op 11  read-modify-write add, when BLRAM_CTRL_RMW_EN is defined.
//            Otherwise it is accepted and rejected with o_done + o_err.
//
// Configuration macro:
//   BLRAM_CTRL_RMW_EN - enables the read-modify-write add command (op 11).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   i_cmd_valid       command request
//   o_cmd_ready       command can be accepted (state == IDLE)
//   i_cmd_op          command opcode
//   i_cmd_addr        start address
//   i_cmd_len         burst length minus one
//   i_cmd_data        write/fill data or RMW addend
//   o_rd_valid        read data valid
//   i_rd_ready        consumer accepts read data
//   o_rd_data         read word
//   o_rd_last         final word of a read burst
//   o_done            one-cycle completion pulse
//   o_err             one-cycle pulse with o_done for an illegal op
//   o_we              RAM write enable
//   o_addr            RAM address
//   o_ram_data_in     RAM write data
//   i_ram_data_out    RAM registered read data
// ----------------------------------------------------------------------------
module blram_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [ADDR_W-1:0] i_cmd_len,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_last,
    output logic              o_done,
    output logic              o_err,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_ram_data_in,
    input  logic [DATA_W-1:0] i_ram_data_out
);

    typedef enum logic [3:0] {
        IDLE,
        RD_ISSUE,
        RD_CAP,
        RD_OUT,
        WRITE,
        FILL,
        RMW_ISSUE,
        RMW_CAP,
        RMW_WR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;     // current burst address, drives o_addr
    logic [ADDR_W-1:0] rem_q, rem_d;       // words left after the current one
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_last_q, rd_last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef BLRAM_CTRL_RMW_EN
    logic [DATA_W-1:0] addend_q, addend_d; // RMW addend held across the RAM read
`endif

    // Ready is the only combinational output; it is forced low during reset.
    assign o_cmd_ready   = (state_q == IDLE) && rst;
    assign o_rd_valid    = rd_valid_q;
    assign o_rd_data     = rd_data_q;
    assign o_rd_last     = rd_last_q;
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign o_we          = we_q;
    assign o_addr        = addr_q;
    assign o_ram_data_in = wdata_q;

    // Next-state and registered-output logic. The RAM-facing outputs are set
    // one edge ahead, so the value computed here is what the RAM sees during
    // the state being entered.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef BLRAM_CTRL_RMW_EN
        addend_d   = addend_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    case (i_cmd_op)
                        2'b00: begin
                            addr_d  = i_cmd_addr;
                            rem_d   = i_cmd_len;
                            state_d = RD_ISSUE;
                        end
                        2'b01: begin
                            addr_d  = i_cmd_addr;
                            wdata_d = i_cmd_data;
                            we_d    = 1'b1;
                            state_d = WRITE;
                        end
                        2'b10: begin
                            addr_d  = i_cmd_addr;
                            rem_d   = i_cmd_len;
                            wdata_d = i_cmd_data;
                            we_d    = 1'b1;
                            state_d = FILL;
                        end
                        default: begin
`ifdef BLRAM_CTRL_RMW_EN
                            addr_d   = i_cmd_addr;
                            addend_d = i_cmd_data;
                            state_d  = RMW_ISSUE;
`else
                            // Unsupported op: reject without touching the RAM.
                            done_d = 1'b1;
                            err_d  = 1'b1;
`endif
                        end
                    endcase
                end
            end

            RD_ISSUE: begin
                state_d = RD_CAP;
            end

            // The RAM's registered output now holds mem[addr_q].
            RD_CAP: begin
                rd_data_d  = i_ram_data_out;
                rd_valid_d = 1'b1;
                rd_last_d  = (rem_q == '0);
                state_d    = RD_OUT;
            end

            RD_OUT: begin
                if (i_rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (rd_last_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        rem_d   = rem_q - ADDR_W'(1);
                        state_d = RD_ISSUE;
                    end
                end
            end

            WRITE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            // Write enable stays high while words remain; address wraps.
            FILL: begin
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - ADDR_W'(1);
                end
            end

`ifdef BLRAM_CTRL_RMW_EN
            RMW_ISSUE: begin
                state_d = RMW_CAP;
            end

            RMW_CAP: begin
                wdata_d = i_ram_data_out + addend_q;
                we_d    = 1'b1;
                state_d = RMW_WR;
            end

            RMW_WR: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef BLRAM_CTRL_RMW_EN
            addend_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef BLRAM_CTRL_RMW_EN
            addend_q   <= addend_d;
`endif
        end
    end

endmodule

// File: tb/tb_blram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_blram_ctrl
//
// Testbench for blram_ctrl. Wraps the controller around a behavioural 64x10
// registered-read RAM. Expected read words are pushed into a queue from an
// array model of memory when each command is issued. A monitor pops and
// compares them as the controller hands words out.
// ----------------------------------------------------------------------------
module tb_blram_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 10;
    localparam int DEPTH = 64;
`ifdef BLRAM_CTRL_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [1:0]    i_cmd_op = '0;
    logic [AW-1:0] i_cmd_addr = '0;
    logic [AW-1:0] i_cmd_len = '0;
    logic [DW-1:0] i_cmd_data = '0;
    logic          o_rd_valid;
    logic          i_rd_ready = 1'b1;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_last;
    logic          o_done;
    logic          o_err;
    logic          o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_ram_data_in;
    logic [DW-1:0] ramOut;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] model [DEPTH];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rd_exp_t;

    rd_exp_t rdQ[$];

    int checks    = 0;
    int errors    = 0;
    int weTotal   = 0;
    int readyMode = 0;
    int stallCnt  = 0;

    blram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_op       (i_cmd_op),
        .i_cmd_addr     (i_cmd_addr),
        .i_cmd_len      (i_cmd_len),
        .i_cmd_data     (i_cmd_data),
        .o_rd_valid     (o_rd_valid),
        .i_rd_ready     (i_rd_ready),
        .o_rd_data      (o_rd_data),
        .o_rd_last      (o_rd_last),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_we           (o_we),
        .o_addr         (o_addr),
        .o_ram_data_in  (o_ram_data_in),
        .i_ram_data_out (ramOut)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read data.
    always @(posedge clk) begin
        if (o_we) ram[o_addr] <= o_ram_data_in;
        ramOut <= ram[o_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_we"},       o_we, 0);
        checkOutput({tag, "_addr"},     o_addr, 0);
        checkOutput({tag, "_wdata"},    o_ram_data_in, 0);
        checkOutput({tag, "_rd_valid"}, o_rd_valid, 0);
        checkOutput({tag, "_rd_data"},  o_rd_data, 0);
        checkOutput({tag, "_rd_last"},  o_rd_last, 0);
        checkOutput({tag, "_done"},     o_done, 0);
        checkOutput({tag, "_err"},      o_err, 0);
        checkOutput({tag, "_cmd_ready"}, o_cmd_ready, 0);
    endtask

    // Consumer ready: 0 = always ready, 1 = random, 2 = stall 5 cycles per word.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0: i_rd_ready = 1'b1;
            1: i_rd_ready = ($urandom_range(0, 2) != 0);
            default: begin
                if (o_rd_valid && stallCnt < 5) begin
                    i_rd_ready = 1'b0;
                    stallCnt++;
                end else if (o_rd_valid) begin
                    i_rd_ready = 1'b1;
                    stallCnt = 0;
                end else begin
                    i_rd_ready = 1'b0;
                end
            end
        endcase
    end

    // Monitor: counts write-enable cycles, checks read words against the
    // scoreboard and checks data stability while the consumer stalls.
    bit            stalled = 1'b0;
    logic [DW-1:0] held;
    rd_exp_t       monExp;

    always @(negedge clk) begin
        if (!rst) begin
            stalled = 1'b0;
        end else begin
            if (o_we) weTotal++;
            if (o_rd_valid) begin
                checkOutput("rd_while_we", o_we, 0);
                if (stalled) checkOutput("rd_stable", o_rd_data, held);
                held = o_rd_data;
                if (i_rd_ready) begin
                    if (rdQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_rd actual=0x%0h required=none", o_rd_data);
                    end else begin
                        monExp = rdQ.pop_front();
                        checkOutput("rd_data", o_rd_data, monExp.data);
                        checkOutput("rd_last", o_rd_last, monExp.last);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Issues one command, updates the memory model, and waits for completion.
    task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr,
                                 input logic [AW-1:0] len, input logic [DW-1:0] data,
                                 input bit checkLat);
        int            weStart;
        int            expWe;
        int            k;
        bit            expErr;
        bit            seen;
        rd_exp_t       x;
        logic [AW-1:0] a;

        expWe  = 0;
        expErr = 1'b0;
        case (op)
            2'b00: begin
                for (int i = 0; i <= int'(len); i++) begin
                    a      = AW'(int'(addr) + i);
                    x.data = model[a];
                    x.last = (i == int'(len));
                    rdQ.push_back(x);
                end
            end
            2'b01: begin
                model[addr] = data;
                expWe = 1;
            end
            2'b10: begin
                for (int i = 0; i <= int'(len); i++) begin
                    a        = AW'(int'(addr) + i);
                    model[a] = data;
                end
                expWe = int'(len) + 1;
            end
            default: begin
                if (RMW_EN) begin
                    model[addr] = model[addr] + data;
                    expWe = 1;
                end else begin
                    expErr = 1'b1;
                end
            end
        endcase

        @(negedge clk);
        k = 0;
        while (!o_cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!o_cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_ready_timeout actual=0 required=1");
            return;
        end
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_addr  = addr;
        i_cmd_len   = len;
        i_cmd_data  = data;
        @(posedge clk);
        #1;
        weStart     = weTotal;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'($urandom);
        i_cmd_addr  = AW'($urandom);
        i_cmd_len   = AW'($urandom);
        i_cmd_data  = DW'($urandom);

        if (checkLat) begin
            for (k = 1; k <= 4; k++) begin
                @(posedge clk);
                #1;
                if (o_rd_valid) break;
            end
            checkOutput("rd_latency", k, 2);
        end

        seen = 1'b0;
        k = 0;
        while (k < 3000) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            k++;
        end
        checkOutput("done_seen", seen, 1);
        if (seen) begin
            checkOutput("err", o_err, expErr);
            checkOutput("ready_at_done", o_cmd_ready, 1);
            checkOutput("we_count", weTotal - weStart, expWe);
            checkOutput("rdq_empty", rdQ.size(), 0);
            @(negedge clk);
            checkOutput("done_width", o_done, 0);
            checkOutput("err_width", o_err, 0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values while rst is held low.
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", o_cmd_ready, 1);

        // Reset in the middle of a fill aborts it immediately.
        i_cmd_valid = 1'b1;
        i_cmd_op    = 2'b10;
        i_cmd_addr  = 6'd10;
        i_cmd_len   = 6'd20;
        i_cmd_data  = 10'h1AB;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checkOutput("we_before_reset", o_we, 1);
        rst = 1'b0;
        #1;
        checkResetOutputs("midfill");
        repeat (3) begin
            @(negedge clk);
            checkOutput("done_in_reset", o_done, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_abort", o_cmd_ready, 1);
        checkOutput("no_done_after_abort", o_done, 0);

        // Bring the whole memory to a known state (64-word fill).
        applyStimulus(2'b10, 6'd0, 6'd63, 10'h000, 1'b0);

        // Write then single-word read with latency check.
        applyStimulus(2'b01, 6'd5, 6'd17, 10'h2A5, 1'b0);
        applyStimulus(2'b00, 6'd5, 6'd0, 10'h000, 1'b1);

        // Fill across the top of the address space, then read it back.
        applyStimulus(2'b10, 6'd62, 6'd3, 10'h155, 1'b0);
        applyStimulus(2'b00, 6'd62, 6'd3, 10'h000, 1'b0);

        // Read with heavy backpressure.
        applyStimulus(2'b01, 6'd0, 6'd0, 10'd1, 1'b0);
        applyStimulus(2'b01, 6'd1, 6'd0, 10'd2, 1'b0);
        applyStimulus(2'b01, 6'd2, 6'd0, 10'd3, 1'b0);
        applyStimulus(2'b01, 6'd3, 6'd0, 10'd4, 1'b0);
        readyMode = 2;
        applyStimulus(2'b00, 6'd0, 6'd3, 10'h000, 1'b0);
        readyMode = 0;

        // Read-modify-write add (or rejection when the feature is absent).
        applyStimulus(2'b01, 6'd7, 6'd0, 10'h3FF, 1'b0);
        applyStimulus(2'b11, 6'd7, 6'd0, 10'd2, 1'b0);
        applyStimulus(2'b00, 6'd7, 6'd0, 10'h000, 1'b0);

        // Randomized command mix with random consumer backpressure.
        for (int n = 0; n < 40; n++) begin
            logic [1:0]    rOp;
            logic [AW-1:0] rAddr;
            logic [AW-1:0] rLen;
            logic [DW-1:0] rData;
            rOp   = 2'($urandom_range(0, 3));
            rAddr = AW'($urandom);
            rLen  = ($urandom_range(0, 9) == 0) ? AW'(63) : AW'($urandom_range(0, 7));
            rData = DW'($urandom);
            readyMode = int'($urandom_range(0, 1));
            applyStimulus(rOp, rAddr, rLen, rData, 1'b0);
        end
        readyMode = 0;

        // Final sweep of the whole memory.
        applyStimulus(2'b00, 6'd0, 6'd63, 10'h000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
